mops_data_generator: RTL and testbench

// - Bench-side MOPS/CAN traffic sequencer for the MOPSHUB 32-bus hub; armed by the hub sign-on.
// - RX test: SDO ADC-read request per bus/channel, checks uplink reply. TX test: checks each frame is routed to its bus downlink.
// - Reports start/end pulses, current bus id, ADC channel and an error count.

---
 rtl/mops_data_generator.sv | 195 +++++++++++++++++++
 tb/tb_mops_data_generator.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mops_data_generator.sv
// Bench-side MOPS/CAN traffic sequencer for the MOPSHUB hub: RX (SDO ADC reads) and TX (downlink routing) tests.
// Optional custom device-type read is compiled in with `define CUSTOM_MSG_EN.
module mops_data_generator #(
  parameter int ADC_FIRST    = 3,
  parameter int ADC_N        = 32,
  parameter int RESP_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_data_gen,
  input  logic [4:0]  n_buses,
  input  logic        test_rx,
  input  logic        test_tx,
  input  logic        test_advanced,
  output logic [75:0] frame_out,
  output logic [4:0]  frame_bus,
  output logic        frame_valid,
  input  logic        frame_ack,
  input  logic        rec_valid,
  input  logic [4:0]  can_rec_select,
  input  logic [75:0] data_rec_uplink,
  input  logic        tra_valid,
  input  logic [4:0]  can_tra_select,
  input  logic [75:0] data_tra_downlink,
  output logic        test_rx_start,
  output logic        test_rx_end,
  output logic        test_tx_start,
  output logic        test_tx_end,
  output logic        costum_msg_end,
  output logic [7:0]  bus_id,
  output logic [5:0]  adc_ch,
  output logic [75:0] bus_dec_data,
  output logic [15:0] err_cnt
);

  localparam int              TW       = $clog2(RESP_TIMEOUT) + 1;
  localparam logic [5:0]      CH_FIRST = 6'(ADC_FIRST);
  localparam logic [5:0]      CH_LAST  = 6'(ADC_FIRST + ADC_N - 1);
  localparam logic [TW-1:0]   T_LAST   = TW'(RESP_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, RX_ISSUE, RX_WAIT, RX_NEXT, TX_ISSUE, TX_WAIT, TX_NEXT
`ifdef CUSTOM_MSG_EN
    , CUS_ISSUE, CUS_WAIT
`endif
  } state_t;

  state_t        state;
  logic          armed;
  logic [4:0]    bus;
  logic [TW-1:0] timer;

  logic [75:0] rx_req, tx_req;
  logic        rx_hit, sdo_ack, rx_ok, tx_ok, timed_out;

  assign rx_req    = {11'h601, 1'b0, 8'h40, 8'h00, 8'h24, 2'b00, adc_ch, 32'h0};
  assign tx_req    = {11'h601, 1'b0, 8'h2F, 8'h00, 8'h24, 8'h00, 24'h0, 3'b000, bus};
  assign rx_hit    = rec_valid && (can_rec_select == bus);
  assign sdo_ack   = (data_rec_uplink[75:65] == 11'h581) && (data_rec_uplink[63:56] == 8'h43);
  assign rx_ok     = sdo_ack && (data_rec_uplink[55:32] == rx_req[55:32]);
  assign tx_ok     = (can_tra_select == bus) && (data_tra_downlink == frame_out);
  assign timed_out = (timer == T_LAST);
  assign bus_id    = {3'b000, bus};

`ifndef CUSTOM_MSG_EN
  logic unused_adv;
  assign unused_adv     = test_advanced;
  assign costum_msg_end = 1'b0;
`endif

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Each issue state loads the frame once, then holds it until the ack is sampled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      armed         <= 1'b0;
      bus           <= '0;
      timer         <= '0;
      adc_ch        <= '0;
      frame_out     <= '0;
      frame_bus     <= '0;
      frame_valid   <= 1'b0;
      test_rx_start <= 1'b0;
      test_rx_end   <= 1'b0;
      test_tx_start <= 1'b0;
      test_tx_end   <= 1'b0;
      bus_dec_data  <= '0;
      err_cnt       <= '0;
`ifdef CUSTOM_MSG_EN
      costum_msg_end <= 1'b0;
`endif
    end else begin
      test_rx_start <= 1'b0;
      test_rx_end   <= 1'b0;
      test_tx_start <= 1'b0;
      test_tx_end   <= 1'b0;
`ifdef CUSTOM_MSG_EN
      costum_msg_end <= 1'b0;
`endif
      if (start_data_gen) armed <= 1'b1;
      case (state)
        IDLE: if (armed) begin
          bus    <= '0;
          adc_ch <= CH_FIRST;
          if (test_rx) begin
            test_rx_start <= 1'b1;
            state         <= RX_ISSUE;
          end else if (test_tx) begin
            test_tx_start <= 1'b1;
            state         <= TX_ISSUE;
          end
`ifdef CUSTOM_MSG_EN
          else if (test_advanced) state <= CUS_ISSUE;
`endif
        end
        RX_ISSUE: if (!frame_valid) begin
          frame_out   <= rx_req;
          frame_bus   <= bus;
          frame_valid <= 1'b1;
        end else if (frame_ack) begin
          frame_valid <= 1'b0;
          timer       <= '0;
          state       <= RX_WAIT;
        end
        RX_WAIT: if (rx_hit) begin
          bus_dec_data <= data_rec_uplink;
          if (!rx_ok) err_cnt <= sat_inc(err_cnt);
          state <= RX_NEXT;
        end else if (timed_out) begin
          err_cnt <= sat_inc(err_cnt);
          state   <= RX_NEXT;
        end else timer <= timer + TW'(1);
        RX_NEXT: if (adc_ch != CH_LAST) begin
          adc_ch <= adc_ch + 6'd1;
          state  <= RX_ISSUE;
        end else begin
          adc_ch <= CH_FIRST;
          if (bus == n_buses) begin
            test_rx_end <= 1'b1;
            state       <= IDLE;
          end else begin
            bus   <= bus + 5'd1;
            state <= RX_ISSUE;
          end
        end
        TX_ISSUE: if (!frame_valid) begin
          frame_out   <= tx_req;
          frame_bus   <= bus;
          frame_valid <= 1'b1;
        end else if (frame_ack) begin
          frame_valid <= 1'b0;
          timer       <= '0;
          state       <= TX_WAIT;
        end
        TX_WAIT: if (tra_valid) begin
          bus_dec_data <= data_tra_downlink;
          if (!tx_ok) err_cnt <= sat_inc(err_cnt);
          state <= TX_NEXT;
        end else if (timed_out) begin
          err_cnt <= sat_inc(err_cnt);
          state   <= TX_NEXT;
        end else timer <= timer + TW'(1);
        TX_NEXT: if (bus == n_buses) begin
          test_tx_end <= 1'b1;
          state       <= IDLE;
        end else begin
          bus   <= bus + 5'd1;
          state <= TX_ISSUE;
        end
`ifdef CUSTOM_MSG_EN
        CUS_ISSUE: if (!frame_valid) begin
          frame_out   <= {11'h601, 1'b0, 64'h4000_1000_0000_0000};
          frame_bus   <= bus;
          frame_valid <= 1'b1;
        end else if (frame_ack) begin
          frame_valid <= 1'b0;
          timer       <= '0;
          state       <= CUS_WAIT;
        end
        CUS_WAIT: if (rx_hit || timed_out) begin
          if (rx_hit) bus_dec_data <= data_rec_uplink;
          if (!rx_hit || !sdo_ack) err_cnt <= sat_inc(err_cnt);
          costum_msg_end <= 1'b1;
          state          <= IDLE;
        end else timer <= timer + TW'(1);
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mops_data_generator.sv
// Scoreboard bench for mops_data_generator: a bus-device model acks frames and answers, a monitor checks requests.
`timescale 1ns/1ps
module tb_mops_data_generator;

  localparam int ADC_FIRST = 3;
  localparam int ADC_N     = 2;
  localparam int TIMEOUT   = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_data_gen, test_rx, test_tx, test_advanced;
  logic [4:0]  n_buses;
  logic [75:0] frame_out;
  logic [4:0]  frame_bus;
  logic        frame_valid, frame_ack;
  logic        rec_valid, tra_valid;
  logic [4:0]  can_rec_select, can_tra_select;
  logic [75:0] data_rec_uplink, data_tra_downlink;
  logic        test_rx_start, test_rx_end, test_tx_start, test_tx_end, costum_msg_end;
  logic [7:0]  bus_id;
  logic [5:0]  adc_ch;
  logic [75:0] bus_dec_data;
  logic [15:0] err_cnt;

  mops_data_generator #(.ADC_FIRST(ADC_FIRST), .ADC_N(ADC_N), .RESP_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start_data_gen(start_data_gen), .n_buses(n_buses),
    .test_rx(test_rx), .test_tx(test_tx), .test_advanced(test_advanced),
    .frame_out(frame_out), .frame_bus(frame_bus), .frame_valid(frame_valid), .frame_ack(frame_ack),
    .rec_valid(rec_valid), .can_rec_select(can_rec_select), .data_rec_uplink(data_rec_uplink),
    .tra_valid(tra_valid), .can_tra_select(can_tra_select), .data_tra_downlink(data_tra_downlink),
    .test_rx_start(test_rx_start), .test_rx_end(test_rx_end), .test_tx_start(test_tx_start),
    .test_tx_end(test_tx_end), .costum_msg_end(costum_msg_end), .bus_id(bus_id), .adc_ch(adc_ch),
    .bus_dec_data(bus_dec_data), .err_cnt(err_cnt));

  always #12.5 clk = ~clk;

  typedef struct packed { logic [4:0] b; logic [75:0] f; } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0, exp_err = 0, cyc = 0;
  int pulse_cnt[5];
  int tx_end_cyc = 0, tx_start_cyc = 0;
  int force_fault = -1;
  bit rand_faults = 0;
  bit seen = 0;

  function automatic logic [75:0] rxReq(input int ch);
    return {11'h601, 1'b0, 8'h40, 8'h00, 8'h24, 8'(ch), 32'h0};
  endfunction

  function automatic logic [75:0] txReq(input int b);
    return {11'h601, 1'b0, 8'h2F, 8'h00, 8'h24, 8'h00, 24'h0, 8'(b)};
  endfunction

  task automatic checkOutput(input string name, input logic [75:0] actual, input logic [75:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic waitCount(input int sel, input int target, input int budget, input string name);
    int n = 0;
    while (pulse_cnt[sel] < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 76'(pulse_cnt[sel]), 76'(target));
  endtask

  // Expected request frames, derived from the test plan rather than the DUT
  task automatic pushRx(input int nb);
    for (int b = 0; b <= nb; b++)
      for (int ch = ADC_FIRST; ch < ADC_FIRST + ADC_N; ch++) sb.push_back({5'(b), rxReq(ch)});
  endtask

  task automatic pushTx(input int nb);
    for (int b = 0; b <= nb; b++) sb.push_back({5'(b), txReq(b)});
  endtask

  task automatic applyStimulus(input bit rx, input int nb, input string name);
    n_buses = 5'(nb);
    if (rx) begin
      pushRx(nb);
      test_rx = 1'b1;
      waitCount(0, pulse_cnt[0] + 1, 20, {name, " start"});
      test_rx = 1'b0;
      waitCount(1, pulse_cnt[1] + 1, 12000, {name, " end"});
    end else begin
      pushTx(nb);
      test_tx = 1'b1;
      waitCount(2, pulse_cnt[2] + 1, 20, {name, " start"});
      test_tx = 1'b0;
      waitCount(3, pulse_cnt[3] + 1, 12000, {name, " end"});
    end
    checkOutput({name, " err_cnt"}, 76'(err_cnt), 76'(exp_err));
    checkOutput({name, " sb empty"}, 76'(sb.size()), 76'd0);
  endtask

  // Pulse counters, sampled just after the active edge
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (test_rx_start) pulse_cnt[0]++;
    if (test_rx_end) pulse_cnt[1]++;
    if (test_tx_start) begin pulse_cnt[2]++; tx_start_cyc = cyc; end
    if (test_tx_end) begin pulse_cnt[3]++; tx_end_cyc = cyc; end
    if (costum_msg_end) pulse_cnt[4]++;
  end

  // Monitor: every newly presented request is matched against the scoreboard head
  always @(negedge clk) begin
    if (frame_valid && !seen) begin
      exp_t e;
      seen = 1'b1;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected frame: got bus %0d frame %h, required none", frame_bus, frame_out);
      end else begin
        e = sb.pop_front();
        if (frame_out !== e.f || frame_bus !== e.b) begin
          errors++;
          $display("[TB] FAIL frame: got bus %0d frame %h, required bus %0d frame %h", frame_bus, frame_out, e.b, e.f);
        end
      end
    end else if (!frame_valid) seen = 1'b0;
  end

  // Bus-device model: ack after a random delay, then answer on the uplink or echo on the downlink
  initial begin : responder
    logic [75:0] f, r;
    logic [4:0]  b;
    int fault;
    frame_ack = 1'b0; rec_valid = 1'b0; tra_valid = 1'b0;
    can_rec_select = '0; can_tra_select = '0; data_rec_uplink = '0; data_tra_downlink = '0;
    forever begin
      @(negedge clk);
      if (frame_valid && rst) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        f = frame_out;
        b = frame_bus;
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        fault = 0;
        if (force_fault >= 0) begin
          fault = force_fault;
          force_fault = -1;
        end else if (rand_faults && $urandom_range(0, 3) == 0) fault = int'($urandom_range(2, 3));
        if (fault != 0) exp_err++;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        if (f[63:56] == 8'h2F) begin
          tra_valid = 1'b1;
          can_tra_select = (fault == 1) ? b ^ 5'd1 : b;
          data_tra_downlink = (fault >= 2) ? f ^ 76'd1 : f;
          rec_valid = 1'b1;
          can_rec_select = b;
          data_rec_uplink = 76'({$urandom(), $urandom(), $urandom()});
        end else begin
          r = {11'h581, 1'b0, 8'h43, f[55:32], $urandom()};
          if (fault == 2) r[63:56] = 8'h80;
          if (fault == 3) r[39:32] = r[39:32] ^ 8'h01;
          rec_valid = 1'b1;
          can_rec_select = (fault == 1) ? b ^ 5'd1 : b;
          data_rec_uplink = r;
          tra_valid = 1'b1;
          can_tra_select = b;
          data_tra_downlink = 76'({$urandom(), $urandom(), $urandom()});
        end
        @(negedge clk);
        rec_valid = 1'b0;
        tra_valid = 1'b0;
      end
    end
  end

  initial begin : main
    int e1, nb, rx0, tx0;
    rst = 1'b0; start_data_gen = 1'b1; test_rx = 1'b0; test_tx = 1'b0; test_advanced = 1'b0; n_buses = '0;
    #5 start_data_gen = 1'b0;
    #5;
    checkOutput("reset frame_out", frame_out, '0);
    checkOutput("reset bus_dec_data", bus_dec_data, '0);
    checkOutput("reset misc", {frame_bus, frame_valid, bus_id, adc_ch, err_cnt},
                76'd0);
    checkOutput("reset pulses", {test_rx_start, test_rx_end, test_tx_start, test_tx_end, costum_msg_end}, '0);
    @(negedge clk) rst = 1'b1;

    $display("[TB] unarmed request");
    test_rx = 1'b1;
    repeat (20) @(negedge clk);
    test_rx = 1'b0;
    checkOutput("unarmed rx_start", 76'(pulse_cnt[0]), 76'd0);
    start_data_gen = 1'b1;
    @(negedge clk) start_data_gen = 1'b0;

    $display("[TB] rx single bus");
    applyStimulus(1'b1, 0, "rx bus0");
    checkOutput("rx adc_ch after end", 76'(adc_ch), 76'(ADC_FIRST));

    $display("[TB] rx random buses with faulty replies");
    nb = int'($urandom_range(1, 3));
    rand_faults = 1'b1;
    applyStimulus(1'b1, nb, "rx random");
    rand_faults = 1'b0;
    checkOutput("rx bus_id after end", 76'(bus_id), 76'(nb));

    $display("[TB] rx reply on foreign bus then timeout");
    force_fault = 1;
    applyStimulus(1'b1, 0, "rx timeout");

    $display("[TB] tx held high loops");
    n_buses = 5'd1;
    pushTx(1);
    pushTx(1);
    tx0 = pulse_cnt[2];
    test_tx = 1'b1;
    waitCount(3, pulse_cnt[3] + 1, 500, "tx loop end1");
    e1 = tx_end_cyc;
    waitCount(2, tx0 + 2, 20, "tx loop restart");
    test_tx = 1'b0;
    checkOutput("tx restart gap", 76'(tx_start_cyc - e1), 76'd1);
    waitCount(3, pulse_cnt[3] + 1, 500, "tx loop end2");
    checkOutput("tx loop err_cnt", 76'(err_cnt), 76'(exp_err));
    checkOutput("tx loop sb empty", 76'(sb.size()), 76'd0);

    $display("[TB] tx echo on wrong bus");
    force_fault = 1;
    applyStimulus(1'b0, 0, "tx wrong bus");
    checkOutput("tx wrong bus data", bus_dec_data, txReq(0));

    $display("[TB] rx has priority over tx");
    tx0 = pulse_cnt[2];
    rx0 = pulse_cnt[0];
    n_buses = 5'd0;
    pushRx(0);
    test_rx = 1'b1;
    test_tx = 1'b1;
    waitCount(0, rx0 + 1, 20, "prio rx_start");
    test_rx = 1'b0;
    test_tx = 1'b0;
    waitCount(1, pulse_cnt[1] + 1, 500, "prio rx_end");
    checkOutput("prio no tx_start", 76'(pulse_cnt[2]), 76'(tx0));

`ifdef CUSTOM_MSG_EN
    $display("[TB] custom device-type read");
    sb.push_back({5'd0, 11'h601, 1'b0, 64'h4000_1000_0000_0000});
    test_advanced = 1'b1;
    @(negedge clk) test_advanced = 1'b0;
    waitCount(4, 1, 500, "custom end");
    checkOutput("custom err_cnt", 76'(err_cnt), 76'(exp_err));
    checkOutput("custom sb empty", 76'(sb.size()), 76'd0);
`else
    $display("[TB] test_advanced ignored");
    test_advanced = 1'b1;
    repeat (20) @(negedge clk);
    test_advanced = 1'b0;
    checkOutput("advanced no frame", 76'(frame_valid), 76'd0);
    checkOutput("advanced no end", 76'(pulse_cnt[4]), 76'd0);
`endif

    $display("[TB] reset mid-test");
    rx0 = pulse_cnt[1];
    n_buses = 5'd2;
    pushRx(2);
    test_rx = 1'b1;
    waitCount(0, pulse_cnt[0] + 1, 20, "abort rx_start");
    test_rx = 1'b0;
    repeat (25) @(negedge clk);
    rst = 1'b0;
    #2;
    checkOutput("abort frame_valid", 76'(frame_valid), 76'd0);
    checkOutput("abort err_cnt", 76'(err_cnt), 76'd0);
    sb.delete();
    exp_err = 0;
    @(negedge clk) rst = 1'b1;
    test_rx = 1'b1;
    repeat (300) @(negedge clk);
    test_rx = 1'b0;
    checkOutput("abort no end pulse", 76'(pulse_cnt[1]), 76'(rx0));
    checkOutput("abort disarmed", 76'(frame_valid | test_rx_start), 76'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #3ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
